// File: rtl/i8253_bus_sequencer.sv
// Host-side sequencer for the 8253 timer: turns single program or latch-and-read requests
// into timed CS_n/RD_n/WR_n/A/D bus cycles. Keeps a shadow of each counter's programmed RW
// mode so a read fetches the right number of bytes in the right order.
module i8253_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        wreset1,
  // Request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_sel,
  input  logic [2:0]  req_mode,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_count,
  // Response channel (no backpressure)
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic        busy,
  // 8253 bus
  output logic        bus_cs_n,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic [1:0]  bus_a,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSetup,
    StStrobe,
    StHold,
    StRecov,
    StResp
  } state_e;

  localparam logic [7:0] SetupLast  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] StrobeLast = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HoldLast   = 8'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // cycles spent in the current bus phase
  logic [1:0]  step_q, step_d;     // 0 = control/latch write, 1..2 = data bytes
  logic [1:0]  seq_rw_q, seq_rw_d; // byte sequence for this transaction
  logic        err_q, err_d;
  logic [15:0] data_q, data_d;
  logic [2:0][1:0] shadow_q, shadow_d;

  // Captured request fields
  logic        op_q;
  logic [1:0]  sel_q;
  logic [2:0]  mode_q;
  logic [1:0]  rw_q;
  logic [15:0] count_q;

  logic        accept;
  logic [1:0]  sel_shadow;
  logic        req_bad;
  logic [1:0]  last_step;
  logic        cyc_is_read;
  logic        cyc_is_msb;
  logic [7:0]  cyc_wdata;
  logic        in_cycle;

  assign req_ready = (state_q == StIdle) & ~wreset1;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != StIdle);

  // Shadow RW of the selected counter; an illegal select reads as unprogrammed.
  always_comb begin
    sel_shadow = 2'b00;
    unique case (sel_q)
      2'd0:    sel_shadow = shadow_q[0];
      2'd1:    sel_shadow = shadow_q[1];
      2'd2:    sel_shadow = shadow_q[2];
      default: sel_shadow = 2'b00;
    endcase
  end

  // Request validation, evaluated in CHECK against the captured fields.
  always_comb begin
    req_bad = 1'b0;
    if (sel_q == 2'd3) begin
      req_bad = 1'b1;
    end else if (!op_q) begin
      req_bad = (rw_q == 2'b00) || (mode_q > 3'd5);
    end else begin
      req_bad = (sel_shadow == 2'b00);
    end
  end

  // Decode of the bus cycle selected by step_q.
  always_comb begin
    last_step   = (seq_rw_q == 2'b11) ? 2'd2 : 2'd1;
    cyc_is_read = op_q && (step_q != 2'd0);
    // Single-byte MSB mode has its only data byte at step 1; otherwise step 2 is the MSB.
    cyc_is_msb  = (seq_rw_q == 2'b10) || (step_q == 2'd2);
    if (step_q == 2'd0) begin
      cyc_wdata = op_q ? {sel_q, 6'b000000} : {sel_q, rw_q, mode_q, 1'b0};
    end else begin
      cyc_wdata = cyc_is_msb ? count_q[15:8] : count_q[7:0];
    end
  end

  // Next-state logic for the transaction FSM, phase counter, read data and shadow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    seq_rw_d = seq_rw_q;
    err_d    = err_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCheck;
      end
      StCheck: begin
        cnt_d  = '0;
        step_d = 2'd0;
        data_d = '0;
        if (req_bad) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          err_d    = 1'b0;
          seq_rw_d = op_q ? sel_shadow : rw_q;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          // Sample on the last strobe cycle so the timer has the full strobe to drive D.
          if (cyc_is_read) begin
            if (cyc_is_msb) data_d[15:8] = bus_din;
            else            data_d[7:0]  = bus_din;
          end
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StRecov;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRecov: begin
        if (step_q == last_step) begin
          state_d = StResp;
          if (!op_q) begin
            for (int i = 0; i < 3; i++) begin
              if (sel_q == 2'(i)) shadow_d[i] = rw_q;
            end
          end
        end else begin
          step_d  = step_q + 2'd1;
          state_d = StSetup;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or posedge wreset1) begin
    if (wreset1) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      step_q   <= '0;
      seq_rw_q <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      seq_rw_q <= seq_rw_d;
      err_q    <= err_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
    end
  end

  // Capture all request fields on the accepting edge.
  always_ff @(posedge clk or posedge wreset1) begin
    if (wreset1) begin
      op_q    <= 1'b0;
      sel_q   <= '0;
      mode_q  <= '0;
      rw_q    <= '0;
      count_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      sel_q   <= req_sel;
      mode_q  <= req_mode;
      rw_q    <= req_rw;
      count_q <= req_count;
    end
  end

  // Bus and response outputs decoded from the registered state only.
  always_comb begin
    in_cycle  = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
    bus_cs_n  = ~in_cycle;
    bus_a     = in_cycle ? ((step_q == 2'd0) ? 2'b11 : sel_q) : 2'b00;
    bus_dout  = (in_cycle && !cyc_is_read) ? cyc_wdata : 8'h00;
    bus_rd_n  = ~((state_q == StStrobe) && cyc_is_read);
    bus_wr_n  = ~((state_q == StStrobe) && !cyc_is_read);
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid & err_q;
    rsp_data  = rsp_valid ? data_q : 16'h0000;
  end

endmodule

// File: tb/tb_i8253_bus_sequencer.sv
// Scoreboard bench for i8253_bus_sequencer: the driver derives expected bus cycles and
// responses from a transaction-level model; a monitor checks them as the DUT presents them.
module tb_i8253_bus_sequencer;

  localparam int unsigned SETUP_CYC  = 1;
  localparam int unsigned STROBE_CYC = 2;
  localparam int unsigned HOLD_CYC   = 1;
  localparam int BUS_CYC = int'(SETUP_CYC + STROBE_CYC + HOLD_CYC + 1);

  logic        clk = 1'b0;
  logic        wreset1 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [1:0]  req_sel = '0;
  logic [2:0]  req_mode = '0;
  logic [1:0]  req_rw = '0;
  logic [15:0] req_count = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic        busy;
  logic        bus_cs_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic [1:0]  bus_a;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;

  i8253_bus_sequencer #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .wreset1  (wreset1),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_sel  (req_sel),
    .req_mode (req_mode),
    .req_rw   (req_rw),
    .req_count(req_count),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_data (rsp_data),
    .busy     (busy),
    .bus_cs_n (bus_cs_n),
    .bus_rd_n (bus_rd_n),
    .bus_wr_n (bus_wr_n),
    .bus_a    (bus_a),
    .bus_dout (bus_dout),
    .bus_din  (bus_din)
  );

  typedef struct {
    bit       rd;
    bit [1:0] a;
    bit [7:0] d;
  } bus_item_t;

  typedef struct {
    bit        err;
    bit [15:0] data;
    int        cyc;
  } rsp_item_t;

  bus_item_t bus_q[$];
  rsp_item_t rsp_q[$];
  bit [7:0]  din_q[$];
  bit [1:0]  shadow[3];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_rsp_cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_bus(input bit rd, input bit [1:0] a, input bit [7:0] d);
    bus_item_t bi;
    bi.rd = rd;
    bi.a  = a;
    bi.d  = d;
    bus_q.push_back(bi);
  endtask

  // Issue one request; the model computes the bus cycles and response it should cause.
  task automatic do_req(input bit op, input bit [1:0] sel, input bit [2:0] mode,
                        input bit [1:0] rw, input bit [15:0] count, input bit [7:0] lsb,
                        input bit [7:0] msb, input bit keep_valid, input bit b2b);
    int        c0;
    int        waited;
    int        k;
    bit        err;
    bit [1:0]  r;
    bit [15:0] data;
    rsp_item_t ri;
    @(negedge clk);
    req_op    = op;
    req_sel   = sel;
    req_mode  = mode;
    req_rw    = rw;
    req_count = count;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0, want 1");
      req_valid = 1'b0;
      return;
    end
    c0 = cyc;
    if (b2b) check("b2b_accept_cycle", 32'(c0), 32'(last_rsp_cyc + 1));
    k    = 0;
    data = 16'h0000;
    if (sel == 2'd3) err = 1'b1;
    else if (!op)    err = (rw == 2'b00) || (mode > 3'd5);
    else             err = (shadow[sel] == 2'b00);
    if (!err) begin
      if (!op) begin
        push_bus(1'b0, 2'b11, {sel, rw, mode, 1'b0});
        k = 1;
        if (rw[0]) begin push_bus(1'b0, sel, count[7:0]);  k++; end
        if (rw[1]) begin push_bus(1'b0, sel, count[15:8]); k++; end
        shadow[sel] = rw;
      end else begin
        push_bus(1'b0, 2'b11, {sel, 6'b000000});
        k = 1;
        r = shadow[sel];
        if (r[0]) begin push_bus(1'b1, sel, 8'h00); din_q.push_back(lsb); data[7:0]  = lsb; k++; end
        if (r[1]) begin push_bus(1'b1, sel, 8'h00); din_q.push_back(msb); data[15:8] = msb; k++; end
      end
    end
    ri.err  = err;
    ri.data = data;
    ri.cyc  = c0 + 2 + BUS_CYC * k;
    rsp_q.push_back(ri);
    last_rsp_cyc = ri.cyc;
    @(posedge clk);
    if (!keep_valid) begin
      #1;
      req_valid = 1'b0;
    end
  endtask

  // Monitor: checks bus timing/contents, plays the timer's read data, and scores responses.
  initial begin : monitor
    bus_item_t bi;
    rsp_item_t ri;
    bit        strobe;
    bit        prev_strobe;
    int        cs_cnt;
    int        str_cnt;
    prev_strobe = 1'b0;
    cs_cnt      = 0;
    str_cnt     = 0;
    forever begin
      @(negedge clk);
      if (wreset1) begin
        prev_strobe = 1'b0;
        cs_cnt      = 0;
        str_cnt     = 0;
      end else begin
        strobe = !bus_rd_n || !bus_wr_n;
        if (!bus_cs_n) begin
          cs_cnt++;
        end else begin
          if (cs_cnt > 0)
            check("cs_low_span", 32'(cs_cnt), 32'(SETUP_CYC + STROBE_CYC + HOLD_CYC));
          cs_cnt = 0;
        end
        if (strobe && !prev_strobe) begin
          check("one_strobe_low", 32'(bus_rd_n) + 32'(bus_wr_n), 32'd1);
          check("cs_at_strobe", 32'(bus_cs_n), 32'd0);
          check("setup_len", 32'(cs_cnt), 32'(SETUP_CYC + 1));
          if (bus_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_bus_cycle: got A=%0d rd_n=%0b, want no cycle",
                     bus_a, bus_rd_n);
          end else begin
            bi = bus_q.pop_front();
            check("bus_is_read", 32'(!bus_rd_n), 32'(bi.rd));
            check("bus_addr", 32'(bus_a), 32'(bi.a));
            check("bus_dout", 32'(bus_dout), 32'(bi.d));
            if (bi.rd && din_q.size() > 0) bus_din = din_q.pop_front();
          end
          str_cnt = 1;
        end else if (strobe) begin
          str_cnt++;
          if (!bus_rd_n && !bus_wr_n) check("strobe_overlap", {30'b0, bus_rd_n, bus_wr_n}, 32'h1);
        end else if (prev_strobe) begin
          check("strobe_len", 32'(str_cnt), 32'(STROBE_CYC));
          check("cs_in_hold", 32'(bus_cs_n), 32'd0);
        end
        prev_strobe = strobe;
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got err=%0b data=0x%0h, want none", rsp_err, rsp_data);
          end else begin
            ri = rsp_q.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(ri.err));
            check("rsp_data", 32'(rsp_data), 32'(ri.data));
            check("rsp_cycle", 32'(cyc), 32'(ri.cyc));
          end
        end
      end
    end
  end

  initial begin : driver
    int       waited;
    bit       op;
    bit [1:0] sel;
    bit [2:0] mode;
    bit [1:0] rw;
    bit       kv;
    bit       prev_kv;
    for (int i = 0; i < 3; i++) shadow[i] = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus_cs_n), 32'd1);
    check("rst_rd_n", 32'(bus_rd_n), 32'd1);
    check("rst_wr_n", 32'(bus_wr_n), 32'd1);
    check("rst_a", 32'(bus_a), 32'd0);
    check("rst_dout", 32'(bus_dout), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    wreset1 = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Illegal requests: bad select, bad mode, read of an unprogrammed counter
    do_req(1'b0, 2'd3, 3'd0, 2'b11, 16'h1111, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b0, 2'd0, 3'd6, 2'b11, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b1, 2'd1, 3'd0, 2'b00, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0);

    // Programming and read-back
    do_req(1'b0, 2'd1, 3'd3, 2'b11, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b0, 2'd0, 3'd2, 2'b11, 16'hA55A, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b1, 2'd0, 3'd0, 2'b00, 16'h0000, 8'h5A, 8'h03, 1'b0, 1'b0);
    do_req(1'b0, 2'd2, 3'd0, 2'b10, 16'h7700, 8'h00, 8'h00, 1'b0, 1'b0);
    do_req(1'b1, 2'd2, 3'd0, 2'b00, 16'h0000, 8'h99, 8'hC4, 1'b0, 1'b0);

    // Back-to-back with req_valid held high
    do_req(1'b0, 2'd0, 3'd1, 2'b01, 16'h00EE, 8'h00, 8'h00, 1'b1, 1'b0);
    do_req(1'b1, 2'd0, 3'd0, 2'b00, 16'h0000, 8'h3C, 8'hFF, 1'b1, 1'b1);
    do_req(1'b0, 2'd3, 3'd0, 2'b01, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1);
    do_req(1'b1, 2'd1, 3'd0, 2'b00, 16'h0000, 8'h81, 8'h18, 1'b0, 1'b1);

    // Reset in the middle of the MSB write strobe
    do_req(1'b0, 2'd1, 3'd3, 2'b11, 16'hBEEF, 8'h00, 8'h00, 1'b0, 1'b0);
    waited = 0;
    do begin
      @(negedge clk);
      #2;
      waited++;
    end while (!(bus_wr_n == 1'b0 && bus_q.size() == 0) && waited < 100);
    check("reached_msb_strobe", 32'(bus_wr_n), 32'd0);
    wreset1 = 1'b1;
    #1;
    check("abort_cs_n", 32'(bus_cs_n), 32'd1);
    check("abort_wr_n", 32'(bus_wr_n), 32'd1);
    check("abort_dout", 32'(bus_dout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_q.delete();
    bus_q.delete();
    din_q.delete();
    for (int i = 0; i < 3; i++) shadow[i] = 2'b00;
    repeat (2) @(negedge clk);
    wreset1 = 1'b0;
    repeat (20) @(negedge clk);
    do_req(1'b1, 2'd1, 3'd0, 2'b00, 16'h0000, 8'h12, 8'h34, 1'b0, 1'b0);

    // Randomized traffic
    prev_kv = 1'b0;
    for (int i = 0; i < 80; i++) begin
      op   = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      mode = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rw   = 2'($urandom_range(0, 3));
      kv   = 1'($urandom_range(0, 1));
      do_req(op, sel, mode, rw, 16'($urandom), 8'($urandom), 8'($urandom), kv, prev_kv);
      prev_kv = kv;
    end
    @(negedge clk);
    req_valid = 1'b0;

    waited = 0;
    while (rsp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("idle_at_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
